// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 DCT scheduler: state encodings, default
// timing parameters and the transpose address-width derivation.
package dct_pkg;

  localparam int DCT_ROW_LAT   = 8;
  localparam int DCT_TRANS_LEN = 32;

  function automatic int addr_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  localparam int DCT_ADDR_W = addr_width(DCT_TRANS_LEN);

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_DCT  = 3'd1,
    W_LOAD = 3'd2
  } w_state_e;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_UNLOAD = 3'd1,
    R_DCT    = 3'd2
  } r_state_e;

endpackage

// File: rtl/dct_stage_timer.sv
// Stage timer: counts while enabled, wraps to 0 after the terminal count,
// and flags the terminal cycle. The count doubles as the transpose address.
module dct_stage_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == tc);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dct_sched.sv
// Ping-pong scheduler for the 1D DCT / transpose / 2D DCT pipeline.
// Optional perf counters are built when DCT_SCHED_PERF_EN is defined.
module dct_sched
  import dct_pkg::*;
#(
  parameter int ROW_LAT   = DCT_ROW_LAT,
  parameter int TRANS_LEN = DCT_TRANS_LEN,
  parameter int ADDR_W    = addr_width(TRANS_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  output logic              blk_ready,
  output logic              load_1dct,
  output logic              load_trans,
  output logic              trans_wr_bank,
  output logic [ADDR_W-1:0] trans_wr_addr,
  output logic              unload_trans,
  output logic              trans_rd_bank,
  output logic [ADDR_W-1:0] trans_rd_addr,
  output logic              load_2dct,
  output logic              blk_done,
  output logic              busy,
  output logic [15:0]       perf_blocks,
  output logic [15:0]       perf_stalls
);

  localparam int ROW_W = addr_width(ROW_LAT);
  localparam int TMR_W = (ADDR_W > ROW_W) ? ADDR_W : ROW_W;

  w_state_e   w_state_q, w_state_d;
  r_state_e   r_state_q, r_state_d;
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;

  logic             w_clr, w_en, w_last, set_full;
  logic             r_clr, r_en, r_last, clr_full;
  logic [TMR_W-1:0] w_tc, r_tc, w_cnt, r_cnt;

  dct_stage_timer #(.W(TMR_W)) u_w_timer (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .tc  (w_tc),
    .cnt (w_cnt),
    .last(w_last)
  );

  dct_stage_timer #(.W(TMR_W)) u_r_timer (
    .clk (clk),
    .rst (rst),
    .clr (r_clr),
    .en  (r_en),
    .tc  (r_tc),
    .cnt (r_cnt),
    .last(r_last)
  );

  // Write side only ever targets an empty bank, so acceptance waits on it.
  assign blk_ready = (w_state_q == W_IDLE) && !full_q[wr_bank_q];

  always_comb begin
    w_state_d = w_state_q;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    w_tc      = '0;
    set_full  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        w_clr = 1'b1;
        if (load && blk_ready) w_state_d = W_DCT;
      end
      W_DCT: begin
        w_en = 1'b1;
        w_tc = TMR_W'(ROW_LAT - 1);
        if (w_last) w_state_d = W_LOAD;
      end
      W_LOAD: begin
        w_en = 1'b1;
        w_tc = TMR_W'(TRANS_LEN - 1);
        if (w_last) begin
          set_full  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_clr     = 1'b1;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_clr     = 1'b0;
    r_en      = 1'b0;
    r_tc      = '0;
    clr_full  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        r_clr = 1'b1;
        if (full_q[rd_bank_q]) r_state_d = R_UNLOAD;
      end
      R_UNLOAD: begin
        r_en = 1'b1;
        r_tc = TMR_W'(TRANS_LEN - 1);
        if (r_last) begin
          clr_full  = 1'b1;
          r_state_d = R_DCT;
        end
      end
      R_DCT: begin
        r_en = 1'b1;
        r_tc = TMR_W'(ROW_LAT - 1);
        if (r_last) r_state_d = R_IDLE;
      end
      default: begin
        r_clr     = 1'b1;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Set and clear hit different banks by construction, so both apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (set_full) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (clr_full) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign load_1dct     = (w_state_q == W_DCT) || (w_state_q == W_LOAD);
  assign load_trans    = (w_state_q == W_LOAD);
  assign trans_wr_bank = wr_bank_q;
  assign trans_wr_addr = load_trans ? w_cnt[ADDR_W-1:0] : '0;
  assign unload_trans  = (r_state_q == R_UNLOAD);
  assign trans_rd_bank = rd_bank_q;
  assign trans_rd_addr = unload_trans ? r_cnt[ADDR_W-1:0] : '0;
  assign load_2dct     = (r_state_q == R_UNLOAD) || (r_state_q == R_DCT);
  assign blk_done      = (r_state_q == R_DCT) && r_last;
  assign busy          = (w_state_q != W_IDLE) || (r_state_q != R_IDLE) || (|full_q);

`ifdef DCT_SCHED_PERF_EN
  logic [15:0] perf_blocks_q, perf_blocks_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_blocks_d = perf_blocks_q;
    perf_stalls_d = perf_stalls_q;
    if (blk_done && (perf_blocks_q != 16'hFFFF))
      perf_blocks_d = perf_blocks_q + 16'd1;
    if (load && !blk_ready && (perf_stalls_q != 16'hFFFF))
      perf_stalls_d = perf_stalls_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_blocks_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_blocks_q <= perf_blocks_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_blocks = perf_blocks_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_blocks = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_dct_sched.sv
// Directed bench for dct_sched: single block, back-to-back blocks, mid-burst
// reset, reset-vs-load priority and illegal write-state recovery.
module tb_dct_sched;
  import dct_pkg::*;

  localparam int AW   = DCT_ADDR_W;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic          blk_ready, load_1dct, load_trans, trans_wr_bank;
  logic [AW-1:0] trans_wr_addr, trans_rd_addr;
  logic          unload_trans, trans_rd_bank, load_2dct, blk_done, busy;
  logic [15:0]   perf_blocks, perf_stalls;

  always #5 clk = ~clk;

  dct_sched dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .blk_ready    (blk_ready),
    .load_1dct    (load_1dct),
    .load_trans   (load_trans),
    .trans_wr_bank(trans_wr_bank),
    .trans_wr_addr(trans_wr_addr),
    .unload_trans (unload_trans),
    .trans_rd_bank(trans_rd_bank),
    .trans_rd_addr(trans_rd_addr),
    .load_2dct    (load_2dct),
    .blk_done     (blk_done),
    .busy         (busy),
    .perf_blocks  (perf_blocks),
    .perf_stalls  (perf_stalls)
  );

  typedef struct packed {
    logic          ready;
    logic          l1;
    logic          lt;
    logic          wb;
    logic [AW-1:0] wa;
    logic          ut;
    logic          rb;
    logic [AW-1:0] ra;
    logic          l2;
    logic          done;
    logic          bsy;
    logic          anyo;
    logic [1:0]    full;
  } smp_t;

  smp_t smp[MAXC];
  int   acc_n;
  int   acc_cyc[8];
  int   stall_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic any_out();
    return load_1dct | load_trans | trans_wr_bank | (|trans_wr_addr) | unload_trans |
           trans_rd_bank | (|trans_rd_addr) | load_2dct | blk_done | busy |
           (|perf_blocks) | (|perf_stalls);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst  = 1'b0;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // mode 0: load for cycle 0 only; mode 1: hold load until max_acc accepts.
  task automatic run(input int ncyc, input int mode, input int max_acc, input int rst_at);
    acc_n   = 0;
    stall_n = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      rst  = (k == rst_at) ? 1'b0 : 1'b1;
      load = (mode == 0) ? (k == 0) : (acc_n < max_acc);
      @(negedge clk);
      smp[k] = '{blk_ready, load_1dct, load_trans, trans_wr_bank, trans_wr_addr,
                 unload_trans, trans_rd_bank, trans_rd_addr, load_2dct, blk_done,
                 busy, any_out(), dut.full_q};
      if (load && !blk_ready) stall_n++;
      if (load && blk_ready && rst) begin
        if (acc_n < 8) acc_cyc[acc_n] = k;
        acc_n++;
      end
    end
    @(posedge clk); #1;
    load = 1'b0;
    rst  = 1'b1;
  endtask

  // Isolated-block timeline relative to the accept cycle b.
  task automatic check_block(input string tag, input int b);
    int e_l1, e_lt, e_wa, e_ut, e_ra, e_l2, e_dn;
    logic [AW-1:0] ewa, era;
    e_l1 = 0; e_lt = 0; e_wa = 0; e_ut = 0; e_ra = 0; e_l2 = 0; e_dn = 0;
    for (int j = 0; j < 90; j++) begin
      ewa = (j >= 9 && j <= 40) ? AW'(j - 9) : '0;
      era = (j >= 42 && j <= 73) ? AW'(j - 42) : '0;
      if (smp[b+j].l1 !== (j >= 1 && j <= 40)) e_l1++;
      if (smp[b+j].lt !== (j >= 9 && j <= 40)) e_lt++;
      if (smp[b+j].wa !== ewa) e_wa++;
      if (smp[b+j].ut !== (j >= 42 && j <= 73)) e_ut++;
      if (smp[b+j].ra !== era) e_ra++;
      if (smp[b+j].l2 !== (j >= 42 && j <= 81)) e_l2++;
      if (smp[b+j].done !== (j == 81)) e_dn++;
    end
    check({tag, "_load_1dct_err_cycles"}, e_l1, 0);
    check({tag, "_load_trans_err_cycles"}, e_lt, 0);
    check({tag, "_wr_addr_err_cycles"}, e_wa, 0);
    check({tag, "_unload_trans_err_cycles"}, e_ut, 0);
    check({tag, "_rd_addr_err_cycles"}, e_ra, 0);
    check({tag, "_load_2dct_err_cycles"}, e_l2, 0);
    check({tag, "_blk_done_err_cycles"}, e_dn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, dpos[4];

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_outputs_zero", 32'(any_out()), 0);
    check("rst_blk_ready", 32'(blk_ready), 1);

    // Single block
    run(90, 0, 1, -1);
    check_block("t1", 0);
    check("t1_accepts", acc_n, 1);
    check("t1_busy_c0", 32'(smp[0].bsy), 0);
    check("t1_ready_c40", 32'(smp[40].ready), 0);
    check("t1_ready_c41", 32'(smp[41].ready), 1);
    check("t1_full_c41", 32'(smp[41].full), 1);
    check("t1_busy_c81", 32'(smp[81].bsy), 1);
    check("t1_busy_c82", 32'(smp[82].bsy), 0);
    check("t1_wr_bank_end", 32'(trans_wr_bank), 1);
    check("t1_rd_bank_end", 32'(trans_rd_bank), 1);
`ifdef DCT_SCHED_PERF_EN
    check("t1_perf_blocks", 32'(perf_blocks), 1);
    check("t1_perf_stalls", 32'(perf_stalls), 0);
`else
    check("t1_perf_blocks", 32'(perf_blocks), 0);
    check("t1_perf_stalls", 32'(perf_stalls), 0);
`endif

    // Three blocks with load held high
    do_reset();
    run(170, 1, 3, -1);
    check("t2_accepts", acc_n, 3);
    check("t2_acc0_cycle", acc_cyc[0], 0);
    check("t2_acc1_cycle", acc_cyc[1], 41);
    check("t2_acc2_cycle", acc_cyc[2], 82);
    check("t2_stall_cycles", stall_n, 80);
    check("t2_unload2_c82", 32'(smp[82].ut), 0);
    check("t2_unload2_c83", 32'(smp[83].ut), 1);
    check("t2_rd_bank_c83", 32'(smp[83].rb), 1);
    check("t2_wr_bank_c42", 32'(smp[42].wb), 1);
    dn = 0;
    for (int k = 0; k < 170; k++) begin
      if (smp[k].done) begin
        if (dn < 4) dpos[dn] = k;
        dn++;
      end
    end
    check("t2_done_count", dn, 3);
    check("t2_done0_cycle", dpos[0], 81);
    check("t2_done1_cycle", dpos[1], 122);
    check("t2_done2_cycle", dpos[2], 163);
    check("t2_busy_end", 32'(busy), 0);
`ifdef DCT_SCHED_PERF_EN
    check("t2_perf_blocks", 32'(perf_blocks), 3);
    check("t2_perf_stalls", 32'(perf_stalls), 80);
`else
    check("t2_perf_blocks", 32'(perf_blocks), 0);
    check("t2_perf_stalls", 32'(perf_stalls), 0);
`endif

    // Reset in the middle of a two-block burst, then a fresh block
    do_reset();
    run(60, 1, 2, 50);
    check("t4_accepts", acc_n, 2);
    check("t4_busy_c50", 32'(smp[50].bsy), 1);
    check("t4_outputs_c51", 32'(smp[51].anyo), 0);
    check("t4_ready_c51", 32'(smp[51].ready), 1);
    check("t4_full_c51", 32'(smp[51].full), 0);
    run(90, 0, 1, -1);
    check_block("t4r", 0);
    check("t4r_wr_bank_c9", 32'(smp[9].wb), 0);
    check("t4r_rd_bank_c42", 32'(smp[42].rb), 0);

    // Load and reset in the same edge
    @(posedge clk); #1;
    rst  = 1'b0;
    load = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    check("t5_load_1dct", 32'(load_1dct), 0);
    check("t5_w_state", 32'(dut.w_state_q), 32'(W_IDLE));
    check("t5_busy", 32'(busy), 0);

    // Illegal write-state encoding
    @(negedge clk);
    force dut.w_state_q = w_state_e'(3'd7);
    #1 release dut.w_state_q;
    check("t6_enables_illegal", 32'({load_1dct, load_trans}), 0);
    @(posedge clk); #1;
    check("t6_w_state", 32'(dut.w_state_q), 32'(W_IDLE));
    check("t6_enables_after", 32'({load_1dct, load_trans, unload_trans, load_2dct}), 0);
    check("t6_ready_after", 32'(blk_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
